// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline valid/advance controller.
package pipe_ctrl_pkg;
  localparam int STAGES_DEF = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_ctrl_v_if.sv
// Upstream/downstream handshake plus flush/drain control for pipe_ctrl_v.
interface pipe_ctrl_v_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic flush_req;
  logic drain_req;
  logic drain_done;

  modport master (
    output in_valid, out_ready, flush_req, drain_req,
    input  in_ready, out_valid, drain_done
  );

  modport slave (
    input  in_valid, out_ready, flush_req, drain_req,
    output in_ready, out_valid, drain_done
  );
endinterface

// File: rtl/pipe_reg_v.sv
// One valid bit of the controlled pipeline; clr wins over d when we is set.
module pipe_reg_v (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic clr,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= 1'b0;
    else if (we) q <= clr ? 1'b0 : d;
  end
endmodule

// File: rtl/pipe_ctrl_v.sv
// Bubble-collapsing pipeline controller: per-stage enables/clears, occupancy,
// and a RUN/DRAIN/FLUSH mode FSM.
module pipe_ctrl_v
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_v_if.slave      bus,
  output logic [STAGES-1:0] stage_we,
  output logic [STAGES-1:0] stage_clr,
  output logic [CW-1:0]     occupancy
);
  state_t            state, state_nxt;
  logic [STAGES-1:0] v, en, vin, v_we, v_clr;
  logic              accept, kill, empty, drain_done_c;

  // Advance chain: a stage moves if it is empty or the stage ahead moves.
  always_comb begin
    en[STAGES-1] = !v[STAGES-1] | bus.out_ready;
    for (int k = STAGES-2; k >= 0; k--) en[k] = !v[k] | en[k+1];
  end

  assign bus.in_ready  = (state == RUN) & en[0] & !rst;
  assign bus.out_valid = v[STAGES-1] & !rst;
  assign accept        = bus.in_valid & bus.in_ready;
  assign vin           = {v[STAGES-2:0], accept};
  assign empty         = (v == '0);

  always_comb begin
    stage_we  = en;
    stage_clr = en & ~vin;
    if (rst || state == FLUSH) begin
      stage_we  = '1;
      stage_clr = '1;
    end
  end

  // Valid bits drop already on the edge that samples flush_req, so out_valid
  // is low throughout the FLUSH cycle.
  assign kill  = bus.flush_req & (state != FLUSH);
  assign v_we  = stage_we  | {STAGES{kill}};
  assign v_clr = stage_clr | {STAGES{kill}};

  for (genvar k = 0; k < STAGES; k++) begin : g_vld
    pipe_reg_v u_vld (
      .clk (clk),
      .rst (rst),
      .we  (v_we[k]),
      .clr (v_clr[k]),
      .d   (vin[k]),
      .q   (v[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    drain_done_c = 1'b0;
    case (state)
      RUN: begin
        if (bus.flush_req)      state_nxt = FLUSH;
        else if (bus.drain_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.flush_req) state_nxt = FLUSH;
        else if (empty) begin
          state_nxt    = RUN;
          drain_done_c = 1'b1;
        end
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign bus.drain_done = drain_done_c & !rst;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) occupancy = occupancy + CW'(v[k]);
    if (rst) occupancy = '0;
  end
endmodule

// File: tb/tb_pipe_ctrl_v.sv
// Directed vector table plus hand-written drain/flush/reset/toggle sequences.
module tb_pipe_ctrl_v;
  localparam int STAGES = 4;
  localparam int CW     = 4;

  logic              clk, rst;
  logic [STAGES-1:0] stage_we, stage_clr;
  logic [CW-1:0]     occupancy;
  int                n_cmp = 0;
  int                n_bad = 0;

  pipe_ctrl_v_if bus ();

  pipe_ctrl_v #(.STAGES(STAGES), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stage_we  (stage_we),
    .stage_clr (stage_clr),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       r, iv, ordy, fl, dr;
    logic       ir, ov, dd;
    logic [3:0] we, clr, occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic r, logic iv, logic ordy, logic fl, logic dr,
                              logic ir, logic ov, logic dd, logic [3:0] we, logic [3:0] clr,
                              logic [3:0] occ);
    vec_t t;
    t.nm = nm; t.r = r; t.iv = iv; t.ordy = ordy; t.fl = fl; t.dr = dr;
    t.ir = ir; t.ov = ov; t.dd = dd; t.we = we; t.clr = clr; t.occ = occ;
    return t;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic iv, logic ordy, logic fl, logic dr);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush_req = fl;
    bus.drain_req = dr;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, del, dd_seen;
    bit done;

    rst = 1'b1;
    bus.in_valid = 0; bus.out_ready = 1; bus.flush_req = 0; bus.drain_req = 0;

    //              name      r iv or fl dr   ir ov dd  we     clr    occ
    tbl.push_back(mk("rst0",  1, 0, 1, 0, 0,  0, 0, 0, 4'hF, 4'hF, 4'd0));
    tbl.push_back(mk("rst1",  1, 0, 1, 0, 0,  0, 0, 0, 4'hF, 4'hF, 4'd0));
    tbl.push_back(mk("idle",  0, 0, 1, 0, 0,  1, 0, 0, 4'hF, 4'hF, 4'd0));
    tbl.push_back(mk("fill0", 0, 1, 1, 0, 0,  1, 0, 0, 4'hF, 4'hE, 4'd0));
    tbl.push_back(mk("fill1", 0, 1, 1, 0, 0,  1, 0, 0, 4'hF, 4'hC, 4'd1));
    tbl.push_back(mk("fill2", 0, 1, 1, 0, 0,  1, 0, 0, 4'hF, 4'h8, 4'd2));
    tbl.push_back(mk("fill3", 0, 1, 1, 0, 0,  1, 0, 0, 4'hF, 4'h0, 4'd3));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("strm%0d", i), 0, 1, 1, 0, 0, 1, 1, 0, 4'hF, 4'h0, 4'd4));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk($sformatf("stall%0d", i), 0, 1, 0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd4));
    tbl.push_back(mk("rel0",  0, 0, 1, 0, 0,  1, 1, 0, 4'hF, 4'h1, 4'd4));
    tbl.push_back(mk("rel1",  0, 0, 1, 0, 0,  1, 1, 0, 4'hF, 4'h3, 4'd3));
    tbl.push_back(mk("rel2",  0, 0, 1, 0, 0,  1, 1, 0, 4'hF, 4'h7, 4'd2));
    tbl.push_back(mk("rel3",  0, 0, 1, 0, 0,  1, 1, 0, 4'hF, 4'hF, 4'd1));
    tbl.push_back(mk("pf0",   0, 1, 1, 0, 0,  1, 0, 0, 4'hF, 4'hE, 4'd0));
    tbl.push_back(mk("pf1",   0, 1, 1, 0, 0,  1, 0, 0, 4'hF, 4'hC, 4'd1));
    tbl.push_back(mk("pf2",   0, 1, 1, 0, 0,  1, 0, 0, 4'hF, 4'h8, 4'd2));
    tbl.push_back(mk("flreq", 0, 0, 1, 1, 0,  1, 0, 0, 4'hF, 4'h1, 4'd3));
    tbl.push_back(mk("flush", 0, 1, 1, 0, 0,  0, 0, 0, 4'hF, 4'hF, 4'd0));
    tbl.push_back(mk("postf", 0, 0, 1, 0, 0,  1, 0, 0, 4'hF, 4'hF, 4'd0));

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].dr);
      chk({tbl[i].nm, ".in_ready"},   bus.in_ready,   tbl[i].ir);
      chk({tbl[i].nm, ".out_valid"},  bus.out_valid,  tbl[i].ov);
      chk({tbl[i].nm, ".drain_done"}, bus.drain_done, tbl[i].dd);
      chk({tbl[i].nm, ".stage_we"},   stage_we,       tbl[i].we);
      chk({tbl[i].nm, ".stage_clr"},  stage_clr,      tbl[i].clr);
      chk({tbl[i].nm, ".occupancy"},  occupancy,      tbl[i].occ);
      @(negedge clk);
    end

    // Drain with two tokens in flight.
    drive(1, 1, 0, 0); @(negedge clk);
    drive(1, 1, 0, 0); @(negedge clk);
    drive(0, 1, 0, 1);
    chk("drain.occ_start", occupancy, 4'd2);
    @(negedge clk);
    del = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      drive(0, 1, 0, 0);
      chk("drain.in_ready_low", bus.in_ready, 1'b0);
      if (bus.out_valid) del++;
      if (bus.drain_done) begin
        chk("drain.results", del[7:0], 8'd2);
        done = 1;
      end
      @(negedge clk);
    end
    chk("drain.completed", done, 1'b1);
    drive(0, 1, 0, 0);
    chk("drain.pulse_single", bus.drain_done, 1'b0);
    chk("drain.in_ready_back", bus.in_ready, 1'b1);
    @(negedge clk);

    // Drain entered with an empty pipeline.
    drive(0, 1, 0, 1); @(negedge clk);
    drive(0, 1, 0, 0);
    chk("edrain.done", bus.drain_done, 1'b1);
    chk("edrain.in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    drive(0, 1, 0, 0);
    chk("edrain.done_clear", bus.drain_done, 1'b0);
    chk("edrain.in_ready_back", bus.in_ready, 1'b1);
    @(negedge clk);

    // flush_req and drain_req together: flush wins, no drain_done.
    drive(1, 1, 0, 0); @(negedge clk);
    drive(1, 1, 0, 0); @(negedge clk);
    drive(0, 1, 1, 1); @(negedge clk);
    drive(0, 1, 0, 0);
    chk("fd.stage_we", stage_we, 4'hF);
    chk("fd.stage_clr", stage_clr, 4'hF);
    chk("fd.in_ready", bus.in_ready, 1'b0);
    chk("fd.out_valid", bus.out_valid, 1'b0);
    dd_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.drain_done) dd_seen++;
      @(negedge clk);
      drive(0, 1, 0, 0);
    end
    chk("fd.no_drain_done", dd_seen[7:0], 8'd0);
    chk("fd.occ", occupancy, 4'd0);
    chk("fd.in_ready_back", bus.in_ready, 1'b1);
    @(negedge clk);

    // Reset in the middle of a drain with three tokens held.
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 0); @(negedge clk);
    end
    drive(0, 0, 0, 1); @(negedge clk);
    drive(0, 0, 0, 0);
    chk("rd.occ_before", occupancy, 4'd3);
    chk("rd.in_ready_drain", bus.in_ready, 1'b0);
    dd_seen = 0;
    if (bus.drain_done) dd_seen++;
    rst = 1'b1;
    #1;
    if (bus.drain_done) dd_seen++;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 0);
    chk("rd.occ_after", occupancy, 4'd0);
    chk("rd.run", bus.in_ready, 1'b1);
    chk("rd.out_valid", bus.out_valid, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (bus.drain_done) dd_seen++;
      @(negedge clk);
      drive(0, 1, 0, 0);
    end
    chk("rd.no_drain_done", dd_seen[7:0], 8'd0);
    @(negedge clk);

    // out_ready toggling every cycle: no lost or duplicated tokens.
    acc = 0; del = 0;
    for (int c = 0; c < 60 && !(acc == 10 && del == 10); c++) begin
      drive(acc < 10, c[0], 0, 0);
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid && bus.out_ready) del++;
      @(negedge clk);
    end
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 0, 0);
      if (bus.out_valid) del++;
      @(negedge clk);
    end
    chk("tog.accepted", acc[7:0], 8'd10);
    chk("tog.delivered", del[7:0], 8'd10);
    chk("tog.occ_end", occupancy, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_v.md
PIPE_CTRL_V -- requirements
Module: pipe_ctrl_v

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of pipeline register stages controlled (legal range 2..8).
REQ-002 SHALL have parameter CW, default 4, width of occupancy output (must satisfy 2^CW > STAGES).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  output  1  controller accepts operands this cycle.
REQ-007 SHALL have port out_valid  output  1  last stage holds a valid result.
REQ-008 SHALL have port out_ready  input  1  downstream consumes result this cycle.
REQ-009 SHALL have port flush_req  input  1  single-cycle request to discard all in-flight data.
REQ-010 SHALL have port drain_req  input  1  single-cycle request to stop intake and empty pipeline.
REQ-011 SHALL have port drain_done  output  1  one-cycle pulse when drain completes.
REQ-012 SHALL have port stage_we  output  STAGES  per-stage write enable to datapath registers.
REQ-013 SHALL have port stage_clr  output  STAGES  per-stage clear (loads zero when qualified by stage_we).
REQ-014 SHALL have port occupancy  output  CW  count of valid stages.

Function
REQ-015 SHALL keep valid bit v[k] per stage; stage 0 is the input stage, stage STAGES-1 drives out_valid.
REQ-016 SHALL compute advance en[STAGES-1] = !v[STAGES-1] | out_ready; en[k] = !v[k] | en[k+1] for k<STAGES-1 (combinational, bubble-collapsing).
REQ-017 SHALL drive stage_we = en in RUN and DRAIN; all-ones in FLUSH.
REQ-018 SHALL drive in_ready = en[0] only in RUN; 0 in DRAIN, FLUSH and during rst.
REQ-019 SHALL, on en[k], load v[0] <= in_valid & in_ready and v[k] <= v[k-1] for k>0.
REQ-020 SHALL drive stage_clr[k] = stage_we[k] & !(incoming valid), so bubbles propagate as zero data; all-ones in FLUSH.
REQ-021 SHALL give latency exactly STAGES cycles from accepted input to out_valid with out_ready held high; throughput one result per cycle.
REQ-022 SHALL hold out_valid and last-stage data stable (stage_we[STAGES-1]=0) while out_valid=1 and out_ready=0.
REQ-023 SHALL implement FSM states RUN, DRAIN, FLUSH; RUN -> FLUSH on flush_req; RUN -> DRAIN on drain_req; DRAIN -> RUN with drain_done=1 in the cycle all v==0; DRAIN -> FLUSH on flush_req; FLUSH -> RUN unconditionally after one cycle.
REQ-024 SHALL give flush_req priority over drain_req when both asserted; flush_req during FLUSH is ignored.
REQ-025 SHALL, in DRAIN entered with pipeline already empty, pulse drain_done the next cycle and return to RUN.
REQ-026 SHALL clear all v in FLUSH; out_valid=0 from the cycle after flush_req accepted.
REQ-027 SHALL report occupancy = popcount(v), registered-state based, range 0..STAGES.
REQ-028 SHALL not lose or duplicate tokens when out_ready toggles every cycle.

Reset
REQ-029 SHALL, with rst=1 at a rising edge, set state RUN, all v=0, drain_done=0.
REQ-030 SHALL, while rst=1, drive in_ready=0, out_valid=0, occupancy=0, stage_we=all-ones, stage_clr=all-ones so datapath zeroes.
REQ-031 SHALL abort DRAIN or FLUSH on rst without asserting drain_done.

Structure
REQ-032 SHALL place FSM state enumeration (RUN, DRAIN, FLUSH) and default STAGES in shared package pipe_ctrl_pkg.
REQ-033 SHALL instantiate one 1-bit pipe_reg_v per stage for valid bits (clr/we driven per REQ-017..020); next-state, enable chain and popcount in this module.

Verification
REQ-034 SHALL cover: STAGES=4, out_ready=1, in_valid=1 for 8 cycles -> first out_valid 4 cycles after first accept, 8 consecutive results, occupancy peaks at 4.
REQ-035 SHALL cover: pipeline full, out_ready=0 for 5 cycles -> in_ready=0, out_valid held, stage_we=0000, occupancy=4; release -> 4 results in 4 cycles.
REQ-036 SHALL cover: occupancy 3, flush_req pulse -> next cycle stage_we=1111, stage_clr=1111, then RUN with occupancy=0, out_valid=0.
REQ-037 SHALL cover: occupancy 2, drain_req, out_ready=1 -> in_ready=0, 2 results delivered, drain_done single pulse, then in_ready=1.
REQ-038 SHALL cover: flush_req and drain_req same cycle -> FLUSH taken, no drain_done.
REQ-039 SHALL cover: rst asserted mid-DRAIN with occupancy 3 -> next cycle occupancy=0, state RUN, drain_done never asserted.
